load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named as below.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req  in  1  memory op request from the EX/MEM stage.
- store  in  1  1=store, 0=load.
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- unsigned_ld  in  1  zero-extend sub-word loads.
- addr  in  32  byte address.
- st_data  in  32  store data, right-aligned.
- busy  out  1  stall request to the pipeline.
- done  out  1  one-cycle completion pulse.
- ld_data  out  32  extended load result.
- misalign  out  1  misaligned-access pulse.
- mem_rd  out  1  data memory read strobe.
- mem_wr  out  1  data memory write strobe.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  memory write word.
- mem_rdata  in  32  memory read word, valid in the cycle after mem_rd.

Function
REQ-003 Memory layout SHALL be big-endian: byte offset 0 maps to bits [31:24] and offset 3 to bits [7:0]; half offset 0 maps to [31:16] and offset 2 to [15:0].
REQ-004 Accept rule: a request SHALL be accepted at a rising edge (E0) where req=1 and state=IDLE; addr, size, store, unsigned_ld and st_data SHALL be captured at E0.
REQ-005 Requests while busy=1 SHALL be ignored; a request held through busy SHALL be accepted exactly once.
REQ-006 FSM states SHALL be IDLE, READ, EXTRACT, MERGE and WRITE.
REQ-007 busy SHALL equal (state != IDLE).
REQ-008 mem_addr SHALL be {captured addr[31:2], 2'b00}.
REQ-009 Loads (all sizes) SHALL follow:
- IDLE -> READ, with mem_rd=1 in READ.
- -> EXTRACT, where mem_rdata is valid.
- -> IDLE at E2; ld_data is registered at E2 and done=1 in the cycle after E2.
REQ-010 Load extraction SHALL be:
- LB: lane selected by addr[1:0], sign-extended; zero-extended if unsigned_ld=1.
- LH: lane selected by addr[1], extended the same way.
- LW: word passed unmodified.
REQ-011 Word stores SHALL follow IDLE -> WRITE (mem_wr=1, mem_wdata=st_data) -> IDLE at E1, with done=1 in the cycle after E1.
REQ-012 Sub-word stores SHALL follow:
- IDLE -> READ (mem_rd=1) -> MERGE.
- In MERGE: mem_wr=1; mem_wdata=mem_rdata with the selected lane replaced by st_data[7:0] (SB) or st_data[15:0] (SH).
- -> IDLE at E2, with done=1 in the cycle after E2.
REQ-013 mem_rd and mem_wr SHALL never be high in the same cycle.
REQ-014 mem_wdata SHALL be 0 outside the WRITE and MERGE states.
REQ-015 ld_data SHALL hold its value until the next load completes; stores and misaligned accesses SHALL leave ld_data unchanged.
REQ-016 A request accepted in the cycle where done=1 SHALL proceed with no bubble.

Reset
REQ-017 At a rst edge: state=IDLE; busy, done, misalign, mem_rd and mem_wr SHALL be 0; ld_data, mem_addr and mem_wdata SHALL be 0.
REQ-018 mem_wr SHALL be gated by !rst, so that rst asserted during MERGE or WRITE prevents the memory write.
REQ-019 rst SHALL take priority over req.

Configuration
REQ-020 With MISALIGN_EXC_EN defined, the misaligned-access behaviour SHALL be:
- An access is misaligned if it is a half with addr[0]=1 or a word with addr[1:0]!=0.
- A misaligned access SHALL be accepted and SHALL return to IDLE at E1 with no mem_rd or mem_wr.
- misalign=1 and done=1 SHALL be asserted in the cycle after E1.
REQ-021 Without MISALIGN_EXC_EN:
- misalign SHALL be tied to 0.
- Misaligned halves SHALL use addr[1] only.
- Misaligned words SHALL ignore addr[1:0].

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Loads, word@0x10=0xA1B2C3D4: LB 0x12 -> 0xFFFFFFC3; LBU 0x12 -> 0x000000C3; LH 0x12 -> 0xFFFFC3D4; LHU 0x10 -> 0x0000A1B2; done 3 cycles after accept.
- Sub-word stores, word@0x20=0xA1B2C3D4: SB 0x55 @0x21 -> word 0xA155C3D4; SH 0x9988 @0x22 -> 0xA1559988; one mem_rd then one mem_wr each.
- SW 0xDEADBEEF @0x40, then LW 0x40 accepted in the SW done cycle -> ld_data 0xDEADBEEF; busy never high during the done cycle.
- LW @0x42 with MISALIGN_EXC_EN -> misalign=1, done=1 at cycle 2, no strobes; without the macro -> reads word 0x40.
- rst high during MERGE -> mem_wr=0, memory unchanged, busy=0 next cycle, done not asserted.
- req held high through a load -> exactly one READ issued, one done pulse.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one memory op at a time against a word-wide, one-cycle-latency data memory.
// Optional MISALIGN_EXC_EN: misaligned halves/words complete without touching memory.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        store,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] ld_data,
  output logic        misalign,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StRead, StExtract, StMerge, StWrite} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] st_data_q;
  logic [1:0]  size_q;
  logic        store_q;
  logic        unsigned_q;
  logic        mis_q;
  logic        done_q;
  logic        misalign_q;
  logic [31:0] ld_data_q;

  logic        mis_req;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] extracted;
  logic [31:0] merged;

`ifdef MISALIGN_EXC_EN
  assign mis_req = size[1] ? (addr[1:0] != 2'b00) : (size[0] & addr[0]);
`else
  assign mis_req = 1'b0;
`endif

  // Big-endian lanes: offset 0 is the most significant byte/half.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = mem_rdata[31:24];
      2'd1:    lane_b = mem_rdata[23:16];
      2'd2:    lane_b = mem_rdata[15:8];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    if (size_q[1]) begin
      extracted = mem_rdata;
    end else if (size_q[0]) begin
      extracted = {{16{~unsigned_q & lane_h[15]}}, lane_h};
    end else begin
      extracted = {{24{~unsigned_q & lane_b[7]}}, lane_b};
    end
  end

  always_comb begin
    merged = mem_rdata;
    if (size_q[0]) begin
      if (addr_q[1]) merged[15:0] = st_data_q[15:0];
      else           merged[31:16] = st_data_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merged[31:24] = st_data_q[7:0];
        2'd1:    merged[23:16] = st_data_q[7:0];
        2'd2:    merged[15:8]  = st_data_q[7:0];
        default: merged[7:0]   = st_data_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= 32'd0;
      st_data_q  <= 32'd0;
      size_q     <= 2'd0;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      mis_q      <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      ld_data_q  <= 32'd0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            addr_q     <= addr;
            st_data_q  <= st_data;
            size_q     <= size;
            store_q    <= store;
            unsigned_q <= unsigned_ld;
            mis_q      <= mis_req;
            // Misaligned ops pass through EXTRACT only to get a strobe-free cycle.
            if (mis_req)                state_q <= StExtract;
            else if (store && size[1])  state_q <= StWrite;
            else                        state_q <= StRead;
          end
        end
        StRead: state_q <= store_q ? StMerge : StExtract;
        StExtract: begin
          if (mis_q) misalign_q <= 1'b1;
          else       ld_data_q  <= extracted;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        StMerge, StWrite: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      StWrite: mem_wdata = st_data_q;
      StMerge: mem_wdata = merged;
      default: mem_wdata = 32'd0;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign misalign = misalign_q;
  assign ld_data  = ld_data_q;
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign mem_rd   = (state_q == StRead);
  assign mem_wr   = ((state_q == StWrite) || (state_q == StMerge)) && !rst;

endmodule
